ysyx_22040750_axi_rd_arbiter: RTL
=================================

Name: ysyx_22040750_axi_rd_arbiter

Overview:
- Shares the single AXI4 master read channel (AR/R) between the icache refill port and the dcache refill/uncached-load port.
- Sits between the cache block and the io_master_ar*/r* pins. The write channel bypasses this block; the dcache is its only writer.
- Grants one burst at a time and locks the grant from AR acceptance until the rlast beat. Tags ARID, checks burst length, steers R beats back to the owner.

Parameters:
- AW, 32, address width inside the AR payload
- DW, 64, R data width
- ID_I, 4'd0, ARID driven for icache bursts
- ID_D, 4'd1, ARID driven for dcache bursts

Ports:
- I_clk  in  1  system clock
- I_rst_n  in  1  reset, asynchronous, active-low
- I_i_arvalid  in  1  icache read request
- O_i_arready  out  1  icache request accepted
- I_i_ar  in  45  icache AR payload {addr[31:0],len[7:0],size[2:0],burst[1:0]}
- O_i_rvalid  out  1  R beat valid to icache
- I_i_rready  in  1  icache ready for beat
- I_d_arvalid  in  1  dcache read request
- O_d_arready  out  1  dcache request accepted
- I_d_ar  in  45  dcache AR payload, same packing as I_i_ar
- O_d_rvalid  out  1  R beat valid to dcache
- I_d_rready  in  1  dcache ready for beat
- O_rdata  out  64  shared R data, i.e. I_mem_rdata passed through
- O_rlast  out  1  shared rlast, gated by owner
- O_rresp  out  2  shared rresp
- O_mem_arvalid  out  1  AXI arvalid
- I_mem_arready  in  1  AXI arready
- O_mem_ar  out  45  registered AR payload to the AXI pins
- O_mem_arid  out  4  ARID of the current owner
- I_mem_rvalid  in  1  AXI rvalid
- O_mem_rready  out  1  AXI rready
- I_mem_rdata  in  64  AXI rdata
- I_mem_rlast  in  1  AXI rlast
- I_mem_rresp  in  2  AXI rresp
- O_owner  out  2  one-hot current owner {D,I}; 00 when idle
- O_len_err  out  1  sticky: rlast did not arrive on beat len+1

Behaviour:
- Reset, async on I_rst_n low: state IDLE; all valid/ready outputs 0; O_mem_ar 0; O_mem_arid 0; O_owner 00; O_len_err 0; beat counter 0.
- FSM states: IDLE, AR_I, AR_D, R_I, R_D.
- IDLE:
  - Evaluate I_i_arvalid and I_d_arvalid in the same cycle.
  - Winner gets its O_x_arready pulsed high combinationally, for exactly that cycle.
  - Winner's payload is latched into O_mem_ar and its ID into O_mem_arid. Next state is AR_x.
  - Default priority: dcache wins when both requests are valid.
- AR_x:
  - O_mem_arvalid=1. O_mem_ar and O_mem_arid are held stable.
  - On I_mem_arready: go to R_x, clear the beat counter, load expected beats = len+1 (9-bit, 1..256).
  - Request-to-O_mem_arvalid latency is exactly 1 cycle. Back-to-back bursts have a minimum gap of 1 IDLE cycle.
- R_x:
  - O_x_rvalid = I_mem_rvalid. O_mem_rready = I_x_rready. The other requester's rvalid is held 0.
  - O_rdata, O_rresp and O_rlast pass through combinationally; O_rlast is 0 to the non-owner.
  - The counter increments on each rvalid&rready handshake.
  - Handshake with rlast: go to IDLE. If count+1 != expected, set O_len_err.
  - Handshake on the expected final beat without rlast: set O_len_err and stay in R_x until rlast arrives.
- Requests arriving in AR_x or R_x see arready=0 and must hold their payload (AXI stable-until-accept).
- O_owner tracks the state: AR_I/R_I=01, AR_D/R_D=10, IDLE=00.
- I_mem_rresp != OKAY is forwarded unchanged. It does not affect the FSM.
- Reset mid-burst: immediate return to IDLE. Draining in-flight beats is the interconnect's concern. O_len_err is cleared only by reset.

Optional Feature:
- Macro: YSYX_22040750_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_grant register (reset value = I) is updated on each grant. On a simultaneous request the requester not granted last wins.
- Undefined: fixed dcache-over-icache priority, no last_grant register.

Test Plan:
- Icache only, len=3, addr 0x8000_0000; slave returns 4 beats with rlast on beat 4 -> O_mem_arid=0, O_mem_arvalid 1 cycle after request, 4 O_i_rvalid beats, O_d_rvalid stays 0, return to IDLE, O_len_err=0.
- I and D request in the same cycle, both len=1 -> fixed mode: D burst first, then I. RR mode with last_grant=I: D first; second simultaneous pair: I first.
- Dcache request while an icache burst is in R_I -> O_d_arready stays 0 until the icache rlast beat; D is granted on the next IDLE cycle.
- Slave asserts rlast on beat 2 of a len=3 burst -> O_len_err=1 and sticky; FSM returns to IDLE.
- I_i_rready toggled 0/1 every cycle during an 8-beat burst -> O_mem_rready mirrors it, counter counts only handshakes, exactly 8 beats are delivered.
- I_rst_n asserted during R_D at beat 2 -> all outputs 0 asynchronously; state IDLE after release; a new request is served normally.

Source files
------------

// File: rtl/ysyx_22040750_axi_rd_arbiter.sv
// ysyx_22040750_axi_rd_arbiter
// Shares one AXI4 read channel (AR/R) between the icache and dcache refill
// ports. The grant is held for one whole burst, from AR acceptance to the
// rlast beat. ARID tags the owner, R beats go back to the owner, and the
// burst length is checked against the beats actually received.
// Optional feature: define YSYX_22040750_ARB_RR_EN to get round-robin
// arbitration. When it is undefined, dcache has fixed priority over icache.
module ysyx_22040750_axi_rd_arbiter #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 64,
  parameter logic [3:0]  ID_I = 4'd0,
  parameter logic [3:0]  ID_D = 4'd1
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_i_arvalid,
  output logic             O_i_arready,
  input  logic [AW+12:0]   I_i_ar,
  output logic             O_i_rvalid,
  input  logic             I_i_rready,
  input  logic             I_d_arvalid,
  output logic             O_d_arready,
  input  logic [AW+12:0]   I_d_ar,
  output logic             O_d_rvalid,
  input  logic             I_d_rready,
  output logic [DW-1:0]    O_rdata,
  output logic             O_rlast,
  output logic [1:0]       O_rresp,
  output logic             O_mem_arvalid,
  input  logic             I_mem_arready,
  output logic [AW+12:0]   O_mem_ar,
  output logic [3:0]       O_mem_arid,
  input  logic             I_mem_rvalid,
  output logic             O_mem_rready,
  input  logic [DW-1:0]    I_mem_rdata,
  input  logic             I_mem_rlast,
  input  logic [1:0]       I_mem_rresp,
  output logic [1:0]       O_owner,
  output logic             O_len_err
);

  // Payload packing: {addr, len[7:0], size[2:0], burst[1:0]}
  localparam int unsigned PW = AW + 13;

  typedef enum logic [2:0] {IDLE, AR_I, AR_D, R_I, R_D} state_t;

  state_t          state_q;
  logic [PW-1:0]   ar_q;
  logic [3:0]      arid_q;
  logic [8:0]      cnt_q;
  logic [8:0]      exp_q;
  logic            len_err_q;
  logic            pick_d;
  logic            grant_i;
  logic            grant_d;
  logic            r_phase;
  logic            hs;
  logic [8:0]      cnt_d;

`ifdef YSYX_22040750_ARB_RR_EN
  logic            last_d_q;   // 1: dcache received the most recent grant

  // Round-robin: on a tie the requester that was not granted last wins
  always_comb pick_d = I_d_arvalid && (!I_i_arvalid || !last_d_q);
`else
  // Fixed priority: dcache always wins a tie
  always_comb pick_d = I_d_arvalid;
`endif

  // Grant decision, R-phase steering and beat handshake
  always_comb begin
    grant_d = (state_q == IDLE) && pick_d;
    grant_i = (state_q == IDLE) && I_i_arvalid && !pick_d;
    r_phase = (state_q == R_I) || (state_q == R_D);
    O_mem_rready = (state_q == R_I) ? I_i_rready :
                   (state_q == R_D) ? I_d_rready : 1'b0;
    hs      = r_phase && I_mem_rvalid && O_mem_rready;
    cnt_d   = cnt_q + 9'd1;
  end

  // Output decode from the state and the latched AR registers
  always_comb begin
    O_i_arready   = grant_i;
    O_d_arready   = grant_d;
    O_mem_arvalid = (state_q == AR_I) || (state_q == AR_D);
    O_mem_ar      = ar_q;
    O_mem_arid    = arid_q;
    O_i_rvalid    = (state_q == R_I) && I_mem_rvalid;
    O_d_rvalid    = (state_q == R_D) && I_mem_rvalid;
    O_rdata       = I_mem_rdata;
    O_rresp       = I_mem_rresp;
    O_rlast       = r_phase && I_mem_rlast;
    O_owner       = ((state_q == AR_I) || (state_q == R_I)) ? 2'b01 :
                    ((state_q == AR_D) || (state_q == R_D)) ? 2'b10 : 2'b00;
    O_len_err     = len_err_q;
  end

  // Arbitration FSM: grant, AR handshake, beat counting and length check
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= IDLE;
      ar_q      <= '0;
      arid_q    <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      len_err_q <= 1'b0;
`ifdef YSYX_22040750_ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            ar_q    <= I_d_ar;
            arid_q  <= ID_D;
            state_q <= AR_D;
`ifdef YSYX_22040750_ARB_RR_EN
            last_d_q <= 1'b1;
`endif
          end else if (grant_i) begin
            ar_q    <= I_i_ar;
            arid_q  <= ID_I;
            state_q <= AR_I;
`ifdef YSYX_22040750_ARB_RR_EN
            last_d_q <= 1'b0;
`endif
          end
        end
        AR_I, AR_D: begin
          if (I_mem_arready) begin
            cnt_q   <= '0;
            exp_q   <= {1'b0, ar_q[12:5]} + 9'd1;
            state_q <= (state_q == AR_I) ? R_I : R_D;
          end
        end
        R_I, R_D: begin
          if (hs) begin
            cnt_q <= cnt_d;
            if (I_mem_rlast) begin
              state_q <= IDLE;
              if (cnt_d != exp_q) len_err_q <= 1'b1;
            end else if (cnt_d == exp_q) begin
              // Expected last beat came without rlast: flag it and keep draining
              len_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
